// File: rtl/bist_ctrl_param.sv
// Parametrised BIST sequencer: N_RUNS runs of M_PATTERNS LFSR patterns with a 1-cycle gap.
// Define BIST_SIGNATURE_EN to add MISR response compaction and the pass/fail result.
//
// state  | meaning
// S_IDLE | waiting for a start rising edge
// S_TEST | driving patterns, test_en high
// S_GAP  | one idle cycle between runs, next run prepared
// S_DONE | one-cycle bist_end pulse, result latched
module bist_ctrl_param #(
  parameter int              M_PATTERNS = 10,
  parameter int              N_RUNS     = 5,
  parameter int              PAT_W      = 8,
  parameter logic [PAT_W-1:0] LFSR_SEED  = 8'h01,
  parameter logic [PAT_W-1:0] LFSR_TAPS  = 8'hB8,
  parameter logic [PAT_W-1:0] GOLDEN_SIG = 8'h00,
  localparam int             MW         = $clog2(M_PATTERNS),
  localparam int             NW         = (N_RUNS > 1) ? $clog2(N_RUNS) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [PAT_W-1:0] i_dut_resp,
  output logic             o_running,
  output logic             o_test_en,
  output logic [PAT_W-1:0] o_pattern,
  output logic [MW-1:0]    o_count_m,
  output logic [NW-1:0]    o_count_n,
  output logic             o_bist_end,
  output logic             o_pass
);

  localparam logic [MW-1:0] M_LAST = MW'(M_PATTERNS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N_RUNS - 1);

  typedef enum logic [1:0] {S_IDLE, S_TEST, S_GAP, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_sv;
  logic [MW-1:0]    r_count_m;
  logic [NW-1:0]    r_count_n;
  logic [PAT_W-1:0] r_pattern;
  logic             w_start_edge;
  logic             w_run_last;
  logic             w_seq_last;
  logic [PAT_W-1:0] w_lfsr_next;

  assign w_start_edge = (r_sv == 2'b01);
  assign w_run_last   = (r_count_m == M_LAST);
  assign w_seq_last   = (r_count_n == N_LAST);
  assign w_lfsr_next  = (r_pattern >> 1) ^ (r_pattern[0] ? LFSR_TAPS : '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_state_next = S_TEST;
      S_TEST:  if (w_run_last) w_state_next = w_seq_last ? S_DONE : S_GAP;
      S_GAP:   w_state_next = S_TEST;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_running  = 1'b0;
    o_test_en  = 1'b0;
    o_bist_end = 1'b0;
    case (r_state)
      S_TEST:  begin o_running = 1'b1; o_test_en = 1'b1; end
      S_GAP:   o_running = 1'b1;
      S_DONE:  o_bist_end = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sv      <= 2'b00;
      r_count_m <= '0;
      r_count_n <= '0;
      r_pattern <= LFSR_SEED;
    end else begin
      r_sv <= {r_sv[0], i_start};
      case (r_state)
        S_IDLE: if (w_start_edge) begin
          r_count_m <= '0;
          r_count_n <= '0;
          r_pattern <= LFSR_SEED;
        end
        S_TEST: begin
          r_pattern <= w_lfsr_next;
          r_count_m <= w_run_last ? '0 : r_count_m + 1'b1;
        end
        S_GAP: begin
          r_count_n <= r_count_n + 1'b1;
          r_pattern <= LFSR_SEED;
        end
        default: ;
      endcase
    end
  end

  assign o_pattern = r_pattern;
  assign o_count_m = r_count_m;
  assign o_count_n = r_count_n;

`ifdef BIST_SIGNATURE_EN
  logic [PAT_W-1:0] r_misr;
  logic             r_fail;
  logic             r_pass;
  logic             w_misr_bad;
  logic [PAT_W-1:0] w_misr_next;

  assign w_misr_bad  = (r_misr != GOLDEN_SIG);
  assign w_misr_next = ((r_misr >> 1) ^ (r_misr[0] ? LFSR_TAPS : '0)) ^ i_dut_resp;

  // fail is sticky across runs; pass is cleared when a new sequence is accepted
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_misr <= '0;
      r_fail <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start_edge) begin
          r_misr <= '0;
          r_fail <= 1'b0;
          r_pass <= 1'b0;
        end
        S_TEST: r_misr <= w_misr_next;
        S_GAP: begin
          r_fail <= r_fail | w_misr_bad;
          r_misr <= '0;
        end
        S_DONE: begin
          r_fail <= r_fail | w_misr_bad;
          r_misr <= '0;
          r_pass <= ~(r_fail | w_misr_bad);
        end
        default: ;
      endcase
    end
  end

  assign o_pass = r_pass;
`else
  logic w_unused_resp;
  assign w_unused_resp = ^i_dut_resp;
  assign o_pass        = 1'b0;
`endif

endmodule

// File: tb/tb_bist_ctrl_param.sv
// Bench for bist_ctrl_param: cycle model for the default 10x5 instance plus a 2x2 instance
// exercising the signature result.
module tb_bist_ctrl_param;

  localparam int M     = 10;
  localparam int N     = 5;
  localparam int TOTAL = N * M + N - 1;
`ifdef BIST_SIGNATURE_EN
  localparam bit SIG_EN = 1'b1;
`else
  localparam bit SIG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dut_resp = 8'h00;
  logic       running, test_en, bist_end, pass;
  logic [7:0] pattern;
  logic [3:0] count_m;
  logic [2:0] count_n;

  logic       sig_start = 1'b0;
  logic       sig_flip = 1'b0;
  logic [7:0] sig_resp;
  logic       sig_running, sig_test_en, sig_end, sig_pass;
  logic [7:0] sig_pattern;
  logic [0:0] sig_cm, sig_cn;

  always #5 clk = ~clk;

  bist_ctrl_param u_dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_dut_resp(dut_resp),
    .o_running(running), .o_test_en(test_en), .o_pattern(pattern),
    .o_count_m(count_m), .o_count_n(count_n), .o_bist_end(bist_end), .o_pass(pass)
  );

  bist_ctrl_param #(.M_PATTERNS(2), .N_RUNS(2)) u_sig (
    .i_clk(clk), .i_reset(reset), .i_start(sig_start), .i_dut_resp(sig_resp),
    .o_running(sig_running), .o_test_en(sig_test_en), .o_pattern(sig_pattern),
    .o_count_m(sig_cm), .o_count_n(sig_cn), .o_bist_end(sig_end), .o_pass(sig_pass)
  );

  // response mirrors the pattern, optionally corrupted in bit 0 on run 2, pattern 1
  assign sig_resp = sig_pattern ^ {7'b0, sig_flip & sig_test_en & sig_cn[0] & sig_cm[0]};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_at(input int k);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < k; i++) p = p[0] ? ((p >> 1) ^ 8'hB8) : (p >> 1);
    return p;
  endfunction

  // model: m_t is the cycle index inside the running window, -1 when not running
  int m_t = -1;
  int m_cn = 0;
  bit m_done = 1'b0;
  bit m_pass = 1'b0;
  bit h1 = 1'b0;
  bit h2 = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t <= -1; m_cn <= 0; m_done <= 1'b0; m_pass <= 1'b0; h1 <= 1'b0; h2 <= 1'b0;
    end else begin
      if (m_t >= 0) begin
        if (m_t == TOTAL - 1) begin
          m_t <= -1; m_done <= 1'b1;
        end else begin
          m_t <= m_t + 1; m_cn <= (m_t + 1) / (M + 1);
        end
      end else if (m_done) begin
        m_done <= 1'b0; m_pass <= SIG_EN;
      end else if (h1 && !h2) begin
        m_t <= 0; m_cn <= 0; m_pass <= 1'b0;
      end
      h2 <= h1;
      h1 <= start;
    end
  end

  logic e_running, e_test;
  int   e_idx;
  assign e_running = (m_t >= 0);
  assign e_idx     = e_running ? (m_t % (M + 1)) : 0;
  assign e_test    = e_running && (e_idx != M);

  always @(negedge clk) begin
    check("running", running, e_running);
    check("test_en", test_en, e_test);
    check("count_m", count_m, e_test ? e_idx : 0);
    check("count_n", count_n, m_cn);
    check("bist_end", bist_end, m_done);
    check("pass", pass, m_pass);
    if (e_test) check("pattern", pattern, lfsr_at(e_idx));
  end

  logic [7:0] lit [5] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};

  task automatic measure(output int cyc, output int gaps, output int ends, output int end_ok);
    int g, idx, after;
    bit seen, pt;
    logic [3:0] pcm;
    cyc = 0; gaps = 0; ends = 0; end_ok = 0;
    g = 0; idx = 0; after = 0; seen = 1'b0; pt = 1'b0; pcm = '0;
    while (g < 300 && after < 3) begin
      @(negedge clk);
      g++;
      if (running) begin
        seen = 1'b1; cyc++;
        if (!test_en) gaps++;
      end
      if (test_en) begin
        if (idx < 5) check("pattern_lit", pattern, lit[idx]);
        idx++;
      end else idx = 0;
      if (bist_end) begin
        ends++;
        if (pt && pcm == 4'd9) end_ok = 1;
      end
      if (seen && !running) after++;
      pt = test_en;
      pcm = count_m;
    end
  endtask

  int cyc, gaps, ends, end_ok, guard;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset with a toggling start
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2 start = ~start;
    end
    @(posedge clk); #2;
    check("rst_pattern", pattern, 8'h01);
    check("rst_running", running, 0);
    check("rst_count_n", count_n, 0);
    check("rst_pass", pass, 0);
    start = 1'b0; reset = 1'b0;
    repeat (5) @(posedge clk);
    #2 check("idle_no_start", running, 0);

    // basic run, latency from the start edge
    start = 1'b1;
    @(posedge clk); #1 check("lat_edge_k", running, 0);
    @(posedge clk); #1 check("lat_edge_k1", running, 1);
    measure(cyc, gaps, ends, end_ok);
    check("run1_cycles", cyc, 54);
    check("run1_gaps", gaps, 4);
    check("run1_end_pulses", ends, 1);
    check("run1_end_after_last", end_ok, 1);

    // start held high after completion must not retrigger
    repeat (10) @(posedge clk);
    #2 check("held_no_retrigger", running, 0);

    // second run with start glitches while running
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 start = 1'b1;
    fork
      measure(cyc, gaps, ends, end_ok);
      for (int i = 0; i < 4; i++) begin
        repeat (2) @(posedge clk);
        #2 start = i[0];
      end
    join
    check("run2_cycles", cyc, 54);
    check("run2_end_pulses", ends, 1);

    // mid-run reset at run 2, pattern 4
    @(posedge clk); #2 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 start = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end
    while (!(count_n == 3'd2 && count_m == 4'd4 && test_en) && guard < 200);
    check("reach_run2_pat4", guard < 200, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_running", running, 0);
    check("midrst_count_m", count_m, 0);
    check("midrst_count_n", count_n, 0);
    check("midrst_pattern", pattern, 8'h01);
    repeat (2) @(posedge clk);
    #2 begin reset = 1'b0; start = 1'b0; end
    repeat (2) @(posedge clk);
    #2 start = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!running && guard < 20);
    check("restart_seen", running, 1);
    check("restart_count_n", count_n, 0);
    check("restart_count_m", count_m, 0);
    guard = 0;
    do begin @(negedge clk); guard++; end while (running && guard < 100);
    check("restart_finished", running, 0);
    repeat (3) @(posedge clk);

    // signature instance: clean responses, then a single corrupted bit
    for (int pass_no = 0; pass_no < 2; pass_no++) begin
      #2 begin sig_start = 1'b0; sig_flip = pass_no[0]; end
      repeat (3) @(posedge clk);
      #2 sig_start = 1'b1;
      guard = 0; cyc = 0;
      do begin
        @(negedge clk); guard++;
        if (sig_running) cyc++;
      end while (!sig_end && guard < 50);
      check("sig_end_seen", sig_end, 1);
      check("sig_run_cycles", cyc, 5);
      @(negedge clk);
      check(pass_no == 0 ? "sig_pass_clean" : "sig_pass_flipped", sig_pass,
            (pass_no == 0) ? SIG_EN : 1'b0);
      @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bist_ctrl_param.md
Name: bist_ctrl_param

Overview:
- Parametrised successor to the fixed-count BIST controller (3-bit run counter, 4-bit pattern counter, start sampler, two-level FSM).
- Detects a start rising edge and runs N_RUNS test runs of M_PATTERNS cycles each, with a 1-cycle gap between runs.
- Drives an on-chip LFSR pattern to the DUT and pulses bist_end when the sequence completes.
- Optionally compacts the DUT response into a MISR and reports pass/fail against a golden signature.

Parameters:
- M_PATTERNS, 10, patterns per run (>=2); count_m width MW = $clog2(M_PATTERNS).
- N_RUNS, 5, runs per BIST sequence (>=1); count_n width NW = max(1, $clog2(N_RUNS)).
- PAT_W, 8, pattern/response width.
- LFSR_SEED, 8'h01, LFSR load value; must be nonzero.
- LFSR_TAPS, 8'hB8, Galois tap mask, shared by the LFSR and the MISR.
- GOLDEN_SIG, 8'h00, expected per-run MISR signature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  BIST request (level; only a rising edge is used).
- dut_resp  in  PAT_W  DUT response; sampled only with BIST_SIGNATURE_EN.
- running  out  1  high in TEST and GAP.
- test_en  out  1  high in TEST only; pattern is valid when high.
- pattern  out  PAT_W  current LFSR value.
- count_m  out  MW  pattern index within the current run.
- count_n  out  NW  current run index.
- bist_end  out  1  1-cycle pulse on sequence completion.
- pass  out  1  result, valid from bist_end until the next start is accepted.

Behaviour:
- Reset (asynchronous, immediate, also mid-run): FSM=IDLE, start sampler=2'b00, count_m=0, count_n=0, pattern=LFSR_SEED, MISR=0, fail=0, running=0, test_en=0, bist_end=0, pass=0.
- Start sampler: a 2-bit shift register, sv[0]<=start and sv[1]<=sv[0] every cycle in every state. A rising edge means sv==2'b01.
- IDLE:
  - On sv==2'b01: go to TEST; clear count_m, count_n and fail; load pattern=LFSR_SEED; clear MISR.
  - Latency: start goes high before edge k, so running=1 after edge k+1.
  - A start held high never retriggers. A new 0->1 transition is required.
- TEST:
  - test_en=1. Each edge: pattern <= (pattern>>1) ^ (pattern[0] ? LFSR_TAPS : 0), and count_m++.
  - First TEST cycle presents LFSR_SEED.
  - When count_m==M_PATTERNS-1: go to GAP if count_n<N_RUNS-1, else go to DONE. count_m wraps to 0.
- GAP (1 cycle):
  - running=1, test_en=0.
  - count_n++, pattern reloads LFSR_SEED, MISR check then clear (see optional feature). Then go to TEST.
- DONE (1 cycle):
  - running=0, bist_end=1, final MISR check, pass updated. Then go to IDLE.
  - count_n holds N_RUNS-1 until the next start.
- Cycle budget: running is high for exactly N_RUNS*M_PATTERNS + N_RUNS - 1 cycles.
- Start edges while running or in DONE are ignored and not queued. The sampler still tracks start.
- Counters never exceed their terminal values. No wrap other than the count_m wrap at run end.

Optional Feature:
- Macro: BIST_SIGNATURE_EN.
- Defined:
  - Each TEST edge: misr <= ((misr>>1) ^ (misr[0] ? LFSR_TAPS : 0)) ^ dut_resp.
  - In GAP and DONE: if misr!=GOLDEN_SIG, set sticky fail=1; then clear misr.
  - In DONE: pass <= ~fail_next, where fail_next includes this final check.
- Not defined: no MISR logic, dut_resp ignored, pass tied to 0.

Test Plan:
- Reset/idle: reset=1 with toggling start -> all outputs at reset values, pattern=8'h01. Release reset with start low -> no run starts.
- Basic run (M_PATTERNS=10, N_RUNS=5):
  - Stimulus: start 0->1 before edge k.
  - Required: running=1 after edge k+1, held 54 cycles; count_m 0..9, 5 runs.
  - Required: test_en low for exactly 1 cycle between runs; bist_end pulses once, 1 cycle after the last pattern.
- Pattern sequence: first 5 patterns of every run are 01, B8, 5C, 2E, 17, identical across runs.
- Start glitches: pulses 0/1/0/1 while running -> no restart, counts undisturbed. Start held high after bist_end -> stays IDLE until a new rising edge.
- Mid-run reset: reset=1 at run 2, pattern 4 -> immediate return to reset values. Next start edge -> run starts from count_n=0.
- Signature (BIST_SIGNATURE_EN, M_PATTERNS=2, N_RUNS=2, GOLDEN_SIG=8'h00):
  - dut_resp=pattern -> pass=1 at bist_end.
  - Flip dut_resp[0] on run 2, pattern 1 -> signature 8'h01, pass=0.
  - Without the macro -> pass=0 in both cases.
